spike_classifier: RTL and testbench

- Output stage that sits directly downstream of the neuron layer.
- Consumes the layer's per-neuron req/ack spike handshakes and always acknowledges them, so the layer never stalls.
- Counts spikes per output neuron over a programmable observation window.
- At the end of the window, scans the counts and reports the winning neuron index, its count and a tie flag.

---
 rtl/spike_classifier.sv | 158 +++++++++++++++
 tb/tb_spike_classifier.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_classifier.sv
// Counts 4-phase spike handshakes per neuron over a WINDOW-cycle window, then scans for the winner.
// Ack rises/falls 3 edges after req; never stalls the layer; done = WINDOW+NEURONS+1 cycles after start.
module spike_classifier #(
    parameter int NEURONS = 2,
    parameter int CNT_W   = 8,
    parameter int WINDOW  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NEURONS-1:0]         req_in,
    output logic [NEURONS-1:0]         ack_in,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NEURONS)-1:0] winner,
    output logic [CNT_W-1:0]           winner_count,
    output logic                       tie
);
    localparam int IDX_W = $clog2(NEURONS);
    localparam int TMR_W = $clog2(WINDOW + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NEURONS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, COUNT, DECIDE, DONE} top_state_t;
    typedef enum logic {WAIT_REQ, WAIT_REL} hs_state_t;

    top_state_t         r_state, w_state_nxt;
    hs_state_t          r_hs [NEURONS];
    hs_state_t          w_hs_nxt [NEURONS];
    logic [NEURONS-1:0] r_sync1, r_sync2, w_spike, w_ack_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_cnt [NEURONS];
    logic [IDX_W-1:0]   r_idx, r_max_idx, w_max_idx;
    logic [CNT_W-1:0]   r_max, w_max, w_cur;
    logic               r_tie, w_tie;

    always_comb begin
        for (int i = 0; i < NEURONS; i++) begin
            w_hs_nxt[i]  = r_hs[i];
            w_ack_nxt[i] = ack_in[i];
            w_spike[i]   = 1'b0;
            case (r_hs[i])
                WAIT_REQ: if (r_sync2[i]) begin
                    w_hs_nxt[i]  = WAIT_REL;
                    w_ack_nxt[i] = 1'b1;
                    w_spike[i]   = 1'b1;
                end
                WAIT_REL: if (!r_sync2[i]) begin
                    w_hs_nxt[i]  = WAIT_REQ;
                    w_ack_nxt[i] = 1'b0;
                end
                default: w_hs_nxt[i] = WAIT_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            ack_in  <= '0;
            for (int i = 0; i < NEURONS; i++) r_hs[i] <= WAIT_REQ;
        end else begin
            r_sync1 <= req_in;
            r_sync2 <= r_sync1;
            ack_in  <= w_ack_nxt;
            for (int i = 0; i < NEURONS; i++) r_hs[i] <= w_hs_nxt[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_nxt = COUNT;
            COUNT: begin
                busy = 1'b1;
                if (r_timer == '0) w_state_nxt = DECIDE;
            end
            DECIDE: begin
                busy = 1'b1;
                if (r_idx == IDX_LAST) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Running max over the scan; strict > keeps the lowest index on ties.
    always_comb begin
        w_cur     = r_cnt[r_idx];
        w_max     = r_max;
        w_max_idx = r_max_idx;
        w_tie     = r_tie;
        if (r_idx == '0) begin
            w_max     = w_cur;
            w_max_idx = '0;
            w_tie     = 1'b0;
        end else if (w_cur > r_max) begin
            w_max     = w_cur;
            w_max_idx = r_idx;
            w_tie     = 1'b0;
        end else if (w_cur == r_max) begin
            w_tie     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer      <= '0;
            r_idx        <= '0;
            r_max        <= '0;
            r_max_idx    <= '0;
            r_tie        <= 1'b0;
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
            for (int i = 0; i < NEURONS; i++) r_cnt[i] <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_timer <= TMR_LOAD;
                    r_idx   <= '0;
                    for (int i = 0; i < NEURONS; i++) r_cnt[i] <= '0;
                end
                COUNT: begin
                    if (r_timer != '0) r_timer <= r_timer - 1'b1;
                    for (int i = 0; i < NEURONS; i++)
                        if (w_spike[i] && r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                DECIDE: begin
                    r_max     <= w_max;
                    r_max_idx <= w_max_idx;
                    r_tie     <= w_tie;
                    if (r_idx == IDX_LAST) begin
                        r_idx        <= '0;
                        winner       <= w_max_idx;
                        winner_count <= w_max;
                        tie          <= w_tie;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_classifier.sv
// Scoreboard bench for spike_classifier: stimulus pushes expected results, monitors pop on done.
module tb_spike_classifier;
    localparam int W = 64;
    localparam int N = 2;

    logic       clk, rst;
    logic [1:0] req_in, ack_in, req_sat, ack_sat;
    logic       start, busy, done, start_sat, busy_sat, done_sat;
    logic [0:0] winner, winner_sat;
    logic [7:0] winner_count;
    logic [2:0] winner_count_sat;
    logic       tie, tie_sat;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [0:0] w;
        logic [7:0] c;
        logic       t;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t sb_sat[$];

    spike_classifier #(.NEURONS(N), .CNT_W(8), .WINDOW(W)) u_dut (
        .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .start(start),
        .busy(busy), .done(done), .winner(winner), .winner_count(winner_count), .tie(tie)
    );

    spike_classifier #(.NEURONS(N), .CNT_W(3), .WINDOW(W)) u_sat (
        .clk(clk), .rst(rst), .req_in(req_sat), .ack_in(ack_sat), .start(start_sat),
        .busy(busy_sat), .done(done_sat), .winner(winner_sat), .winner_count(winner_count_sat),
        .tie(tie_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("winner", winner, e.w);
                chk("winner_count", winner_count, e.c);
                chk("tie", tie, e.t);
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (done_sat) begin
            if (sb_sat.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done_sat: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb_sat.pop_front();
                chk("sat_winner", winner_sat, e.w);
                chk("sat_winner_count", winner_count_sat, e.c);
                chk("sat_tie", tie_sat, e.t);
                chk("sat_done_cycle", cyc, e.due);
            end
        end
    end

    // Called at a negedge; returns at the negedge right after start is sampled.
    task automatic open_win(input bit sat, input bit push, input logic [0:0] w,
                            input logic [7:0] c, input logic t);
        exp_t e;
        e = '{w: w, c: c, t: t, due: cyc + W + N + 1};
        if (sat) begin
            start_sat = 1'b1;
            if (push) sb_sat.push_back(e);
        end else begin
            start = 1'b1;
            if (push) sb.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        start_sat = 1'b0;
    endtask

    task automatic hs(input bit sat, input logic [1:0] m);
        int t;
        if (sat) req_sat = req_sat | m;
        else     req_in  = req_in | m;
        t = 0;
        do begin @(negedge clk); t++; end
        while ((((sat ? ack_sat : ack_in) & m) != m) && t < 10);
        chk("hs_ack_rise", (sat ? ack_sat : ack_in) & m, m);
        if (sat) req_sat = req_sat & ~m;
        else     req_in  = req_in & ~m;
        t = 0;
        do begin @(negedge clk); t++; end
        while ((((sat ? ack_sat : ack_in) & m) != 2'b00) && t < 10);
        chk("hs_ack_fall", (sat ? ack_sat : ack_in) & m, 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || sb_sat.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("window_done_pending", sb.size() + sb_sat.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_in = '0; req_sat = '0; start = 1'b0; start_sat = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ack", ack_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_winner", winner, 0);
        chk("rst_count", winner_count, 0);
        chk("rst_tie", tie, 0);

        // Handshake latency outside any window.
        @(negedge clk);
        req_in = 2'b01;
        @(negedge clk); chk("ack_rise_e1", ack_in, 2'b00);
        @(negedge clk); chk("ack_rise_e2", ack_in, 2'b00);
        @(negedge clk); chk("ack_rise_e3", ack_in, 2'b01);
        req_in = 2'b00;
        @(negedge clk); chk("ack_fall_e1", ack_in, 2'b01);
        @(negedge clk); chk("ack_fall_e2", ack_in, 2'b01);
        @(negedge clk); chk("ack_fall_e3", ack_in, 2'b00);
        chk("idle_busy", busy, 0);

        // Empty window.
        open_win(0, 1, 1'b0, 8'd0, 1'b1);
        chk("count_busy", busy, 1);
        wait_idle();

        // 5 spikes on neuron 1, 2 on neuron 0.
        open_win(0, 1, 1'b1, 8'd5, 1'b0);
        for (int k = 0; k < 5; k++) hs(0, 2'b10);
        for (int k = 0; k < 2; k++) hs(0, 2'b01);
        wait_idle();

        // Equal counts: lowest index wins with tie.
        open_win(0, 1, 1'b0, 8'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin hs(0, 2'b01); hs(0, 2'b10); end
        wait_idle();

        // Simultaneous spikes on both channels.
        open_win(0, 1, 1'b0, 8'd4, 1'b1);
        for (int k = 0; k < 4; k++) hs(0, 2'b11);
        wait_idle();

        // Neuron 1 spikes in the last COUNT cycle, neuron 0 in the first DECIDE cycle.
        open_win(0, 1, 1'b1, 8'd1, 1'b0);
        repeat (61) @(negedge clk);
        req_in = 2'b10;
        @(negedge clk); req_in = 2'b11;
        @(negedge clk);
        @(negedge clk); chk("edge_ack_last_count", ack_in, 2'b10);
        @(negedge clk); chk("edge_ack_first_decide", ack_in, 2'b11);
        req_in = 2'b00;
        repeat (3) @(negedge clk);
        chk("edge_ack_release", ack_in, 2'b00);
        wait_idle();

        // start during COUNT and during DONE is ignored.
        begin
            int t;
            open_win(0, 1, 1'b1, 8'd1, 1'b0);
            hs(0, 2'b10);
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("start_in_count_busy", busy, 1);
            t = 0;
            while (!done && t < 200) begin @(negedge clk); t++; end
            chk("done_seen", done, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("start_in_done_ignored", busy, 0);
            repeat (3) @(negedge clk);
            chk("still_idle", busy, 0);
            wait_idle();
        end

        // Reset mid-window aborts with outputs cleared.
        open_win(0, 0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 3; k++) hs(0, 2'b01);
        req_in = 2'b01;
        repeat (3) @(negedge clk);
        chk("pre_rst_ack", ack_in, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        req_in = 2'b00;
        chk("mid_rst_ack", ack_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_winner", winner, 0);
        chk("mid_rst_count", winner_count, 0);
        chk("mid_rst_tie", tie, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("post_rst_idle", busy, 0);

        // Fresh window after the abort.
        open_win(0, 1, 1'b1, 8'd2, 1'b0);
        for (int k = 0; k < 2; k++) hs(0, 2'b10);
        wait_idle();

        // 3-bit counters saturate at 7.
        open_win(1, 1, 1'b0, 8'd7, 1'b0);
        for (int k = 0; k < 10; k++) hs(1, 2'b01);
        wait_idle();

        chk("final_queue_empty", sb.size() + sb_sat.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
